// File: rtl/i2c_dp_pkg.sv
// i2c_dp_pkg: command and state encodings for the I2C byte engine.
// The transaction FSM uses the same op_t when it issues commands.
package i2c_dp_pkg;

  // Command opcodes carried on cmd_op.
  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_STOP  = 2'd3
  } op_t;

  // Engine control states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_SHIFT = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

endpackage

// File: rtl/i2c_byte_engine_if.sv
// i2c_byte_engine_if: groups the command handshake (transaction FSM side) and
// the SCL tick / SDA line signals (timing generator and pad side).
//   master : command source + tick/line source (transaction FSM, timing gen, pad)
//   slave  : the byte engine itself
interface i2c_byte_engine_if
  import i2c_dp_pkg::*;
#(
  parameter int DATA_W = 8
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  op_t               cmd_op;
  logic              cmd_nack;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              done;
  logic              ack_nack;
  logic              arb_lost;
  logic              scl_low_tick;
  logic              scl_high_tick;
  logic              sda_in;
  logic              sda_oe;
  logic              scl_en;

  modport master (
    output cmd_valid, cmd_op, cmd_nack, tx_data, scl_low_tick, scl_high_tick, sda_in,
    input  cmd_ready, rx_data, done, ack_nack, arb_lost, sda_oe, scl_en
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_nack, tx_data, scl_low_tick, scl_high_tick, sda_in,
    output cmd_ready, rx_data, done, ack_nack, arb_lost, sda_oe, scl_en
  );
endinterface

// File: rtl/i2c_shift_reg.sv
// i2c_shift_reg: frame shift register for the byte engine.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   load_i       load load_data_i (has priority over shift_i)
//   shift_i      advance one bit, inserting bit_i at the trailing end
//   bit_o        bit currently presented to the line
//   data_o       parallel contents (received frame after DATA_W shifts)
module i2c_shift_reg #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              shift_i,
  input  logic              bit_i,
  output logic              bit_o,
  output logic [DATA_W-1:0] data_o
);
  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] sr_d;

  // Next-state: load, or shift toward the outgoing end while filling the other end.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = load_data_i;
    end else if (shift_i) begin
      if (MSB_FIRST) begin
        sr_d = (sr_q << 1'b1) | DATA_W'(bit_i);
      end else begin
        sr_d = (sr_q >> 1'b1) | (DATA_W'(bit_i) << (DATA_W - 1));
      end
    end else begin
      sr_d = sr_q;
    end
  end

  // Shift register state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign bit_o  = MSB_FIRST ? sr_q[DATA_W-1] : sr_q[0];
  assign data_o = sr_q;
endmodule

// File: rtl/i2c_byte_engine.sv
// i2c_byte_engine: I2C master byte engine on the system clock. Executes one
// START / WRITE / READ / STOP command at a time, paced by SCL low/high ticks.
// Ports:
//   clk    system clock (rising edge)
//   reset  synchronous active-high reset
//   bus    slave side of i2c_byte_engine_if: command handshake, results
//          (rx_data, done, ack_nack, arb_lost), ticks and SDA/SCL controls
module i2c_byte_engine
  import i2c_dp_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  i2c_byte_engine_if.slave      bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic              nack_q, nack_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stop_low_q, stop_low_d;   // STOP: low tick already seen
  logic              sda_oe_q, sda_oe_d;
  logic              scl_en_q, scl_en_d;
  logic              done_q, done_d;
  logic              arb_lost_q, arb_lost_d;
  logic              ack_nack_q, ack_nack_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;

  logic              high_s, low_s;
  logic              sr_load_s, sr_shift_s, sr_bit_s;
  logic [DATA_W-1:0] sr_data_s;

  // A high tick masks a coincident low tick.
  assign high_s = bus.scl_high_tick;
  assign low_s  = bus.scl_low_tick & ~bus.scl_high_tick;

  i2c_shift_reg #(.DATA_W(DATA_W), .MSB_FIRST(MSB_FIRST)) u_sr (
    .clk        (clk),
    .reset      (reset),
    .load_i     (sr_load_s),
    .load_data_i(bus.tx_data),
    .shift_i    (sr_shift_s),
    .bit_i      (bus.sda_in),
    .bit_o      (sr_bit_s),
    .data_o     (sr_data_s)
  );

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    nack_d     = nack_q;
    cnt_d      = cnt_q;
    stop_low_d = stop_low_q;
    sda_oe_d   = sda_oe_q;
    scl_en_d   = scl_en_q;
    done_d     = 1'b0;
    arb_lost_d = 1'b0;
    ack_nack_d = ack_nack_q;
    rx_data_d  = rx_data_q;
    sr_load_s  = 1'b0;
    sr_shift_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        // cmd_ready_q is low in the done cycle, so nothing is accepted there.
        if (bus.cmd_valid && cmd_ready_q) begin
          op_d       = bus.cmd_op;
          nack_d     = bus.cmd_nack;
          cnt_d      = CNT_W'(DATA_W);
          stop_low_d = 1'b0;
          sr_load_s  = 1'b1;
          case (bus.cmd_op)
            OP_START: begin
              state_d  = S_START;
              sda_oe_d = 1'b0;
            end
            OP_WRITE: state_d = S_SHIFT;
            OP_READ:  state_d = S_SHIFT;
            OP_STOP:  state_d = S_STOP;
            default:  state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        // SDA falls while SCL is high.
        if (high_s) begin
          sda_oe_d = 1'b1;
          scl_en_d = 1'b1;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d = S_START;
        end
      end
      S_SHIFT: begin
        if (high_s) begin
          // Released a 1 but the line reads 0: another master owns the bus.
          if ((op_q == OP_WRITE) && sr_bit_s && !bus.sda_in) begin
            arb_lost_d = 1'b1;
            done_d     = 1'b1;
            sda_oe_d   = 1'b0;
            scl_en_d   = 1'b0;
            state_d    = S_IDLE;
          end else begin
            sr_shift_s = 1'b1;
            cnt_d      = (cnt_q == CNT_W'(0)) ? CNT_W'(0) : cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
              state_d = S_ACK;
            end else begin
              state_d = S_SHIFT;
            end
          end
        end else if (low_s) begin
          sda_oe_d = (op_q == OP_WRITE) ? ~sr_bit_s : 1'b0;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_ACK: begin
        if (high_s) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          if (op_q == OP_WRITE) begin
            ack_nack_d = bus.sda_in;
          end else begin
            rx_data_d = sr_data_s;
          end
        end else if (low_s) begin
          sda_oe_d = (op_q == OP_WRITE) ? 1'b0 : ~nack_q;
        end else begin
          state_d = S_ACK;
        end
      end
      S_STOP: begin
        // Only a high tick that follows the low tick releases SDA.
        if (high_s && stop_low_q) begin
          sda_oe_d = 1'b0;
          scl_en_d = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else if (low_s) begin
          sda_oe_d   = 1'b1;
          stop_low_d = 1'b1;
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == S_IDLE) && !done_d;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_START;
      nack_q      <= 1'b0;
      cnt_q       <= '0;
      stop_low_q  <= 1'b0;
      sda_oe_q    <= 1'b0;
      scl_en_q    <= 1'b0;
      done_q      <= 1'b0;
      arb_lost_q  <= 1'b0;
      ack_nack_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      rx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      nack_q      <= nack_d;
      cnt_q       <= cnt_d;
      stop_low_q  <= stop_low_d;
      sda_oe_q    <= sda_oe_d;
      scl_en_q    <= scl_en_d;
      done_q      <= done_d;
      arb_lost_q  <= arb_lost_d;
      ack_nack_q  <= ack_nack_d;
      cmd_ready_q <= cmd_ready_d;
      rx_data_q   <= rx_data_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.done      = done_q;
  assign bus.ack_nack  = ack_nack_q;
  assign bus.arb_lost  = arb_lost_q;
  assign bus.sda_oe    = sda_oe_q;
  assign bus.scl_en    = scl_en_q;
endmodule

// File: tb/tb_i2c_byte_engine.sv
// Bench for i2c_byte_engine: an 8-bit MSB-first instance (A) and a 10-bit
// LSB-first instance (B). Commands are played bit slot by bit slot; after each
// consumed tick the expected outputs are derived from the I2C slot rules and a
// negedge process compares both instances every cycle.
module tb_i2c_byte_engine;
  import i2c_dp_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  i2c_byte_engine_if #(.DATA_W(8))  ifa ();
  i2c_byte_engine_if #(.DATA_W(10)) ifb ();

  i2c_byte_engine #(.DATA_W(8),  .MSB_FIRST(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  i2c_byte_engine #(.DATA_W(10), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  // Shared stimulus; only the selected instance sees valid and ticks.
  logic        sel;
  logic        d_valid, d_low, d_high, d_nack, slave_sda;
  op_t         d_op;
  logic [15:0] d_tx;

  assign ifa.cmd_valid     = d_valid & ~sel;
  assign ifa.cmd_op        = d_op;
  assign ifa.cmd_nack      = d_nack;
  assign ifa.tx_data       = d_tx[7:0];
  assign ifa.scl_low_tick  = d_low & ~sel;
  assign ifa.scl_high_tick = d_high & ~sel;
  assign ifa.sda_in        = ~ifa.sda_oe & (sel ? 1'b1 : slave_sda);
  assign ifb.cmd_valid     = d_valid & sel;
  assign ifb.cmd_op        = d_op;
  assign ifb.cmd_nack      = d_nack;
  assign ifb.tx_data       = d_tx[9:0];
  assign ifb.scl_low_tick  = d_low & sel;
  assign ifb.scl_high_tick = d_high & sel;
  assign ifb.sda_in        = ~ifb.sda_oe & (sel ? slave_sda : 1'b1);

  // Expected outputs per instance.
  logic        exp_ready[2], exp_oe[2], exp_scl[2], exp_done[2], exp_arb[2], exp_ack[2];
  logic [15:0] exp_rx[2];

  int   n_checks = 0;
  int   n_errors = 0;
  logic chk_en   = 1'b0;

  function automatic void check(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("A.cmd_ready", {15'd0, ifa.cmd_ready}, {15'd0, exp_ready[0]});
      check("A.sda_oe",    {15'd0, ifa.sda_oe},    {15'd0, exp_oe[0]});
      check("A.scl_en",    {15'd0, ifa.scl_en},    {15'd0, exp_scl[0]});
      check("A.done",      {15'd0, ifa.done},      {15'd0, exp_done[0]});
      check("A.arb_lost",  {15'd0, ifa.arb_lost},  {15'd0, exp_arb[0]});
      check("A.ack_nack",  {15'd0, ifa.ack_nack},  {15'd0, exp_ack[0]});
      check("A.rx_data",   {8'd0, ifa.rx_data},    exp_rx[0]);
      check("B.cmd_ready", {15'd0, ifb.cmd_ready}, {15'd0, exp_ready[1]});
      check("B.sda_oe",    {15'd0, ifb.sda_oe},    {15'd0, exp_oe[1]});
      check("B.scl_en",    {15'd0, ifb.scl_en},    {15'd0, exp_scl[1]});
      check("B.done",      {15'd0, ifb.done},      {15'd0, exp_done[1]});
      check("B.arb_lost",  {15'd0, ifb.arb_lost},  {15'd0, exp_arb[1]});
      check("B.ack_nack",  {15'd0, ifb.ack_nack},  {15'd0, exp_ack[1]});
      check("B.rx_data",   {6'd0, ifb.rx_data},    exp_rx[1]);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic int width_of();
    return sel ? 10 : 8;
  endfunction

  // Bit index carried by frame slot k of the selected instance.
  function automatic int idx_of(input int k);
    return sel ? k : (width_of() - 1 - k);
  endfunction

  function automatic logic oe_now();
    return sel ? ifb.sda_oe : ifa.sda_oe;
  endfunction

  task automatic reset_exp();
    for (int i = 0; i < 2; i++) begin
      exp_ready[i] = 1'b1; exp_oe[i] = 1'b0; exp_scl[i] = 1'b0; exp_done[i] = 1'b0;
      exp_arb[i] = 1'b0; exp_ack[i] = 1'b0; exp_rx[i] = 16'h0000;
    end
  endtask

  // One clock edge; done/arb_lost are single-cycle pulses and ready returns one cycle after done.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (exp_done[i]) begin
        exp_done[i]  = 1'b0;
        exp_ready[i] = 1'b1;
      end
      exp_arb[i] = 1'b0;
    end
  endtask

  // Optional idle cycles, then a low or high tick (a high tick may carry a masked low tick).
  task automatic tick(input logic hi);
    int n;
    n = int'($urandom_range(0, 2));
    repeat (n) step();
    d_high = hi;
    d_low  = hi ? ($urandom_range(0, 3) == 0) : 1'b1;
    step();
    d_low  = 1'b0;
    d_high = 1'b0;
  endtask

  // Idle cycles with stray ticks; in a done cycle also offer a command that must not be taken.
  task automatic gap();
    int n;
    n = int'($urandom_range(1, 3));
    for (int i = 0; i < n; i++) begin
      d_valid = (i == 0) && exp_done[sel];
      d_op    = op_t'($urandom_range(0, 3));
      d_low   = 1'($urandom_range(0, 1));
      d_high  = 1'($urandom_range(0, 1));
      step();
    end
    d_valid = 1'b0; d_low = 1'b0; d_high = 1'b0;
  endtask

  task automatic accept(input op_t op, input logic [15:0] data, input logic nack);
    gap();
    d_valid = 1'b1; d_op = op; d_tx = data; d_nack = nack;
    step();
    d_valid = 1'b0;
    exp_ready[sel] = 1'b0;
    if (op == OP_START) exp_oe[sel] = 1'b0;
  endtask

  task automatic do_start();
    accept(OP_START, 16'h0000, 1'b0);
    if ($urandom_range(0, 1) == 1) tick(1'b0);
    tick(1'b1);
    exp_oe[sel] = 1'b1; exp_scl[sel] = 1'b1; exp_done[sel] = 1'b1;
  endtask

  task automatic do_write(input logic [15:0] data, input int arb_slot, input logic ack,
                          input int stop_after, output logic lost, output logic [15:0] sent);
    logic b;
    lost = 1'b0;
    sent = 16'h0000;
    accept(OP_WRITE, data, 1'b0);
    for (int k = 0; k < width_of(); k++) begin
      if (k == stop_after) return;
      b = data[idx_of(k)];
      tick(1'b0);
      exp_oe[sel] = ~b;
      if (sel) sent[k] = ~oe_now();
      else     sent = {sent[14:0], ~oe_now()};
      slave_sda = (k == arb_slot) ? 1'b0 : 1'b1;
      tick(1'b1);
      slave_sda = 1'b1;
      if (b && (k == arb_slot)) begin
        exp_arb[sel] = 1'b1; exp_done[sel] = 1'b1; exp_oe[sel] = 1'b0; exp_scl[sel] = 1'b0;
        lost = 1'b1;
        return;
      end
    end
    tick(1'b0);
    exp_oe[sel] = 1'b0;
    slave_sda = ack;
    tick(1'b1);
    slave_sda = 1'b1;
    exp_ack[sel] = ack; exp_done[sel] = 1'b1;
  endtask

  task automatic do_read(input logic [15:0] pattern, input logic nack);
    accept(OP_READ, 16'($urandom), nack);
    for (int k = 0; k < width_of(); k++) begin
      tick(1'b0);
      exp_oe[sel] = 1'b0;
      slave_sda = pattern[idx_of(k)];
      tick(1'b1);
      slave_sda = 1'b1;
    end
    tick(1'b0);
    exp_oe[sel] = ~nack;
    tick(1'b1);
    exp_done[sel] = 1'b1;
    exp_rx[sel]   = pattern & ((16'h0001 << width_of()) - 16'h0001);
  endtask

  task automatic do_stop();
    accept(OP_STOP, 16'h0000, 1'b0);
    tick(1'b0);
    exp_oe[sel] = 1'b1;
    tick(1'b1);
    exp_oe[sel] = 1'b0; exp_scl[sel] = 1'b0; exp_done[sel] = 1'b1;
  endtask

  initial begin
    logic        lost;
    logic [15:0] sent;
    int          n, slot;
    sel = 1'b0; d_valid = 1'b0; d_low = 1'b0; d_high = 1'b0; d_nack = 1'b0;
    d_op = OP_START; d_tx = 16'h0000; slave_sda = 1'b1;
    reset_exp();
    reset = 1'b1;
    repeat (3) step();
    reset_exp();
    chk_en = 1'b1;
    reset  = 1'b0;

    // START + WRITE 8'hA5, slave ACKs.
    do_start();
    do_write(16'h00A5, -1, 1'b0, -1, lost, sent);
    check("a5_sda_bits", sent, 16'h00A5);
    check("a5_ack_nack", {15'd0, ifa.ack_nack}, 16'h0000);

    // READ line pattern 8'h3C, NACK it.
    do_read(16'h003C, 1'b1);
    check("3c_rx_data", {8'd0, ifa.rx_data}, 16'h003C);

    // WRITE 8'hFF, another master pulls bit 5 (slot 2) low.
    do_write(16'h00FF, 2, 1'b0, -1, lost, sent);
    check("ff_lost_flag", {15'd0, lost}, 16'h0001);
    check("ff_arb_lost", {15'd0, ifa.arb_lost}, 16'h0001);
    check("ff_scl_en", {15'd0, ifa.scl_en}, 16'h0000);

    // START, WRITE, STOP.
    do_start();
    do_write(16'($urandom), -1, 1'b0, -1, lost, sent);
    do_stop();
    check("stop_done", {15'd0, ifa.done}, 16'h0001);
    check("stop_scl_en", {15'd0, ifa.scl_en}, 16'h0000);

    // 10-bit LSB-first WRITE 10'h2F1 with slave NACK.
    sel = 1'b1;
    do_start();
    do_write(16'h02F1, -1, 1'b1, -1, lost, sent);
    check("2f1_sda_bits", sent, 16'h02F1);
    check("2f1_ack_nack", {15'd0, ifb.ack_nack}, 16'h0001);
    do_stop();

    // Reset in the middle of a WRITE after three bits.
    sel = 1'b0;
    do_start();
    do_write(16'h00C3, -1, 1'b0, 3, lost, sent);
    reset = 1'b1;
    step();
    reset_exp();
    reset = 1'b0;
    check("rst_sda_oe", {15'd0, ifa.sda_oe}, 16'h0000);
    check("rst_scl_en", {15'd0, ifa.scl_en}, 16'h0000);
    check("rst_cmd_ready", {15'd0, ifa.cmd_ready}, 16'h0001);

    // Random transaction sequences on both instances.
    for (int t = 0; t < 40; t++) begin
      sel = 1'($urandom_range(0, 1));
      do_start();
      lost = 1'b0;
      n = int'($urandom_range(1, 4));
      for (int c = 0; (c < n) && !lost; c++) begin
        case ($urandom_range(0, 4))
          0, 1: begin
            slot = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, width_of() - 1)) : -1;
            do_write(16'($urandom), slot, 1'($urandom_range(0, 1)), -1, lost, sent);
          end
          2, 3: do_read(16'($urandom), 1'($urandom_range(0, 1)));
          default: do_start();
        endcase
      end
      do_stop();
    end
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
